// File: rtl/eth_sw_pkg.sv
// Shared definitions for the 2x2 switch: FIFO word layout, scheduler states, port addresses.
package eth_sw_pkg;

  localparam int SOP_BIT  = 0;
  localparam int DA_LSB   = 1;
  localparam int DA_MSB   = 32;
  localparam int DATA_LSB = 33;
  localparam int DATA_MSB = 64;
  localparam int EOP_BIT  = 65;

  localparam logic PORT_A_ADDR = 1'b0;
  localparam logic PORT_B_ADDR = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } sched_state_e;

endpackage

// File: rtl/eth_sw_rd_sched_if.sv
// Scheduler-facing bundle: FIFO head flags and pop strobes, egress handshake, status and counters.
interface eth_sw_rd_sched_if
  import eth_sw_pkg::*;
#(
  parameter int PORT_COUNT = 2,
  parameter int CNT_WIDTH  = 16
);
  localparam int IDX_W = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;

  // Handshake: a word moves to egress in any cycle where tx_valid is high; tx_valid is
  // only raised when tx_ready is high, so a forwarded word is never left pending.
  logic [PORT_COUNT-1:0]                fifo_empty;
  logic [PORT_COUNT-1:0]                fifo_head_sop;
  logic [PORT_COUNT-1:0]                fifo_head_eop;
  logic                                 tx_ready;
  logic [PORT_COUNT-1:0]                rd_en;
  logic                                 tx_valid;
  logic [IDX_W-1:0]                     grant_id;
  logic                                 pkt_active;
  logic                                 drop_pulse;
  logic                                 timeout_pulse;
  logic [PORT_COUNT-1:0][CNT_WIDTH-1:0] pkt_cnt;
  logic [PORT_COUNT-1:0][CNT_WIDTH-1:0] drop_cnt;
  sched_state_e                         state;

  modport master (
    input  fifo_empty, fifo_head_sop, fifo_head_eop, tx_ready,
    output rd_en, tx_valid, grant_id, pkt_active, drop_pulse, timeout_pulse,
    output pkt_cnt, drop_cnt, state
  );

  modport slave (
    output fifo_empty, fifo_head_sop, fifo_head_eop, tx_ready,
    input  rd_en, tx_valid, grant_id, pkt_active, drop_pulse, timeout_pulse,
    input  pkt_cnt, drop_cnt, state
  );

endinterface

// File: rtl/eth_rr_pick.sv
// Combinational round-robin pick: first set request searching upward from i_ptr+1, wrapping.
module eth_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    // k = N lands back on i_ptr itself, so the last holder is considered last.
    for (int k = 1; k <= N; k++) begin
      if (!o_valid && i_req[(int'(i_ptr) + k) % N]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'((int'(i_ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/eth_sw_rd_sched.sv
// Packet-atomic round-robin read scheduler for the ingress FIFOs; drops orphan words, aborts stalls.
module eth_sw_rd_sched
  import eth_sw_pkg::*;
#(
  parameter int PORT_COUNT     = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic              clk,
  input  logic              rstn,
  eth_sw_rd_sched_if.master bus
);

  localparam int IDX_W = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  sched_state_e                         r_state;
  sched_state_e                         w_next_state;
  logic [IDX_W-1:0]                     r_grant;
  logic [IDX_W-1:0]                     r_rr_ptr;
  logic [TMR_W-1:0]                     r_timer;
  logic [TMR_W-1:0]                     w_timer_next;
  logic [PORT_COUNT-1:0][CNT_WIDTH-1:0] r_pkt_cnt;
  logic [PORT_COUNT-1:0][CNT_WIDTH-1:0] r_drop_cnt;

  logic [IDX_W-1:0]      w_cand;
  logic                  w_cand_vld;
  logic [PORT_COUNT-1:0] w_rd_en;
  logic                  w_tx_valid;
  logic                  w_drop;
  logic                  w_timeout;
  logic                  w_grant_load;
  logic                  w_pkt_done;
  logic                  w_pop;

  eth_rr_pick #(
    .N     (PORT_COUNT),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (~bus.fifo_empty),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_cand),
    .o_valid (w_cand_vld)
  );

  always_comb begin
    w_next_state = r_state;
    w_timer_next = r_timer;
    w_rd_en      = '0;
    w_tx_valid   = 1'b0;
    w_drop       = 1'b0;
    w_timeout    = 1'b0;
    w_grant_load = 1'b0;
    w_pkt_done   = 1'b0;
    w_pop        = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_timer_next = '0;
        if (w_cand_vld) begin
          if (bus.fifo_head_sop[w_cand]) begin
            w_grant_load = 1'b1;
            w_next_state = XFER;
          end else begin
            // Orphan words are flushed regardless of egress backpressure.
            w_rd_en[w_cand] = 1'b1;
            w_drop          = 1'b1;
          end
        end
      end
      XFER: begin
        w_pop              = !bus.fifo_empty[r_grant] && bus.tx_ready;
        w_rd_en[r_grant]   = w_pop;
        w_tx_valid         = w_pop;
        if (w_pop) begin
          w_timer_next = '0;
          if (bus.fifo_head_eop[r_grant]) begin
            w_pkt_done   = 1'b1;
            w_next_state = IDLE;
          end
        end else if (bus.fifo_empty[r_grant] && (TIMEOUT_CYCLES != 0)) begin
          // The pulse lands on the TIMEOUT_CYCLES-th consecutive empty cycle.
          if (r_timer == TMR_LAST) begin
            w_timeout    = 1'b1;
            w_timer_next = '0;
            w_next_state = IDLE;
          end else begin
            w_timer_next = r_timer + TMR_W'(1);
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
    if (!rstn) begin
      w_rd_en      = '0;
      w_tx_valid   = 1'b0;
      w_drop       = 1'b0;
      w_timeout    = 1'b0;
      w_grant_load = 1'b0;
      w_pkt_done   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_timer    <= '0;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      r_timer <= w_timer_next;
      if (w_grant_load) begin
        r_grant  <= w_cand;
        r_rr_ptr <= w_cand;
      end
      if (w_drop) r_drop_cnt[w_cand] <= r_drop_cnt[w_cand] + CNT_WIDTH'(1);
      if (w_pkt_done) r_pkt_cnt[r_grant] <= r_pkt_cnt[r_grant] + CNT_WIDTH'(1);
    end
  end

  assign bus.rd_en         = w_rd_en;
  assign bus.tx_valid      = w_tx_valid;
  assign bus.grant_id      = r_grant;
  assign bus.pkt_active    = (r_state == XFER);
  assign bus.drop_pulse    = w_drop;
  assign bus.timeout_pulse = w_timeout;
  assign bus.pkt_cnt       = r_pkt_cnt;
  assign bus.drop_cnt      = r_drop_cnt;
  assign bus.state         = r_state;

endmodule

// File: tb/tb_eth_sw_rd_sched.sv
// Directed bench for eth_sw_rd_sched: show-ahead FIFO models per port, hand-computed expectations.
module tb_eth_sw_rd_sched;
  import eth_sw_pkg::*;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  // Each queued word is {eop, sop}.
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] pop_snap;

  eth_sw_rd_sched_if #(.PORT_COUNT(2), .CNT_WIDTH(16)) bus ();

  eth_sw_rd_sched #(
    .PORT_COUNT     (2),
    .TIMEOUT_CYCLES (8),
    .CNT_WIDTH      (16)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void refresh();
    bus.fifo_empty[0]    = (q0.size() == 0);
    bus.fifo_head_sop[0] = (q0.size() != 0) ? q0[0][0] : 1'b0;
    bus.fifo_head_eop[0] = (q0.size() != 0) ? q0[0][1] : 1'b0;
    bus.fifo_empty[1]    = (q1.size() == 0);
    bus.fifo_head_sop[1] = (q1.size() != 0) ? q1[0][0] : 1'b0;
    bus.fifo_head_eop[1] = (q1.size() != 0) ? q1[0][1] : 1'b0;
  endfunction

  task automatic push(input int port, input logic sop, input logic eop);
    if (port == 0) q0.push_back({eop, sop});
    else           q1.push_back({eop, sop});
    refresh();
  endtask

  // FIFO pop model: rd_en seen at the edge removes the head shortly after it.
  always @(posedge clk) begin
    pop_snap = bus.rd_en;
    #1;
    if (pop_snap[0] && q0.size() != 0) void'(q0.pop_front());
    if (pop_snap[1] && q1.size() != 0) void'(q1.pop_front());
    refresh();
  end

  always @(negedge clk) begin
    n_checks++;
    if ($countones(bus.rd_en) > 1) begin
      n_errors++;
      $display("FAIL rd_en_onehot got %b exp at most one bit set", bus.rd_en);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    bus.tx_ready = 1'b1;
    q0.delete();
    q1.delete();
    refresh();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.state !== IDLE) begin n_errors++; $display("FAIL rst_state got %0d exp %0d", bus.state, IDLE); end
    n_checks++; if (bus.rd_en !== 2'b00) begin n_errors++; $display("FAIL rst_rd_en got %b exp 00", bus.rd_en); end
    n_checks++; if (bus.tx_valid !== 1'b0) begin n_errors++; $display("FAIL rst_tx_valid got %b exp 0", bus.tx_valid); end
    n_checks++; if (bus.grant_id !== 1'b0) begin n_errors++; $display("FAIL rst_grant got %b exp 0", bus.grant_id); end
    n_checks++; if (bus.pkt_active !== 1'b0) begin n_errors++; $display("FAIL rst_active got %b exp 0", bus.pkt_active); end
    n_checks++; if (bus.drop_pulse !== 1'b0 || bus.timeout_pulse !== 1'b0) begin n_errors++; $display("FAIL rst_pulses got %b%b exp 00", bus.drop_pulse, bus.timeout_pulse); end
    n_checks++; if (bus.pkt_cnt !== 32'd0 || bus.drop_cnt !== 32'd0) begin n_errors++; $display("FAIL rst_cnts got %h/%h exp 0/0", bus.pkt_cnt, bus.drop_cnt); end
  endtask

  task automatic test_single_pkt();
    do_reset();
    push(0, 1'b1, 1'b0); push(0, 1'b0, 1'b0); push(0, 1'b0, 1'b1);
    #1;
    n_checks++; if (bus.rd_en !== 2'b00) begin n_errors++; $display("FAIL single_nopop_idle got %b exp 00", bus.rd_en); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (bus.rd_en !== 2'b01 || bus.tx_valid !== 1'b1) begin n_errors++; $display("FAIL single_pop%0d got rd_en=%b tx_valid=%b exp 01/1", i, bus.rd_en, bus.tx_valid); end
      n_checks++; if (bus.grant_id !== 1'b0 || bus.pkt_active !== 1'b1) begin n_errors++; $display("FAIL single_grant%0d got %b/%b exp 0/1", i, bus.grant_id, bus.pkt_active); end
    end
    @(negedge clk);
    n_checks++; if (bus.state !== IDLE || bus.rd_en !== 2'b00) begin n_errors++; $display("FAIL single_end got state=%0d rd_en=%b exp 0/00", bus.state, bus.rd_en); end
    n_checks++; if (bus.pkt_cnt[0] !== 16'd1 || bus.pkt_cnt[1] !== 16'd0) begin n_errors++; $display("FAIL single_pkt_cnt got %0d/%0d exp 1/0", bus.pkt_cnt[0], bus.pkt_cnt[1]); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rd[6];
    exp_rd = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
    do_reset();
    push(0, 1'b1, 1'b0); push(0, 1'b0, 1'b1);
    push(1, 1'b1, 1'b0); push(1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++; if (bus.rd_en !== exp_rd[i]) begin n_errors++; $display("FAIL b2b_rd_en%0d got %b exp %b", i, bus.rd_en, exp_rd[i]); end
    end
    n_checks++; if (bus.pkt_cnt[0] !== 16'd1 || bus.pkt_cnt[1] !== 16'd1) begin n_errors++; $display("FAIL b2b_pkt_cnt got %0d/%0d exp 1/1", bus.pkt_cnt[0], bus.pkt_cnt[1]); end
    n_checks++; if (bus.state !== IDLE) begin n_errors++; $display("FAIL b2b_end_state got %0d exp 0", bus.state); end
  endtask

  task automatic test_orphan();
    do_reset();
    push(1, 1'b0, 1'b0); push(1, 1'b1, 1'b1);
    #1;
    n_checks++; if (bus.rd_en !== 2'b10 || bus.tx_valid !== 1'b0 || bus.drop_pulse !== 1'b1) begin n_errors++; $display("FAIL orphan_drop got rd_en=%b tx_valid=%b drop=%b exp 10/0/1", bus.rd_en, bus.tx_valid, bus.drop_pulse); end
    @(negedge clk);
    n_checks++; if (bus.drop_cnt[1] !== 16'd1 || bus.drop_pulse !== 1'b0 || bus.rd_en !== 2'b00) begin n_errors++; $display("FAIL orphan_after got cnt=%0d drop=%b rd_en=%b exp 1/0/00", bus.drop_cnt[1], bus.drop_pulse, bus.rd_en); end
    @(negedge clk);
    n_checks++; if (bus.rd_en !== 2'b10 || bus.tx_valid !== 1'b1 || bus.grant_id !== 1'b1) begin n_errors++; $display("FAIL orphan_fwd got rd_en=%b tx_valid=%b grant=%b exp 10/1/1", bus.rd_en, bus.tx_valid, bus.grant_id); end
    @(negedge clk);
    n_checks++; if (bus.pkt_cnt[1] !== 16'd1 || bus.state !== IDLE) begin n_errors++; $display("FAIL orphan_pkt got cnt=%0d state=%0d exp 1/0", bus.pkt_cnt[1], bus.state); end
  endtask

  task automatic test_timeout();
    do_reset();
    push(0, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++; if (bus.rd_en !== 2'b01) begin n_errors++; $display("FAIL to_sop_pop got %b exp 01", bus.rd_en); end
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      n_checks++; if (bus.timeout_pulse !== 1'b0 || bus.pkt_active !== 1'b1) begin n_errors++; $display("FAIL to_wait%0d got pulse=%b active=%b exp 0/1", i, bus.timeout_pulse, bus.pkt_active); end
    end
    @(negedge clk);
    n_checks++; if (bus.timeout_pulse !== 1'b1) begin n_errors++; $display("FAIL to_pulse got %b exp 1", bus.timeout_pulse); end
    @(negedge clk);
    n_checks++; if (bus.timeout_pulse !== 1'b0 || bus.state !== IDLE || bus.pkt_cnt[0] !== 16'd0) begin n_errors++; $display("FAIL to_after got pulse=%b state=%0d cnt=%0d exp 0/0/0", bus.timeout_pulse, bus.state, bus.pkt_cnt[0]); end
    push(0, 1'b0, 1'b1);
    #1;
    n_checks++; if (bus.rd_en !== 2'b01 || bus.drop_pulse !== 1'b1 || bus.tx_valid !== 1'b0) begin n_errors++; $display("FAIL to_late_eop got rd_en=%b drop=%b tx_valid=%b exp 01/1/0", bus.rd_en, bus.drop_pulse, bus.tx_valid); end
    @(negedge clk);
    n_checks++; if (bus.drop_cnt[0] !== 16'd1 || bus.pkt_cnt[0] !== 16'd0) begin n_errors++; $display("FAIL to_cnts got drop=%0d pkt=%0d exp 1/0", bus.drop_cnt[0], bus.pkt_cnt[0]); end
  endtask

  task automatic test_backpressure();
    do_reset();
    push(0, 1'b1, 1'b0); push(0, 1'b0, 1'b0); push(0, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++; if (bus.rd_en !== 2'b01) begin n_errors++; $display("FAIL bp_sop got %b exp 01", bus.rd_en); end
    @(negedge clk);
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      n_checks++; if (bus.rd_en !== 2'b00 || bus.timeout_pulse !== 1'b0 || bus.pkt_active !== 1'b1) begin n_errors++; $display("FAIL bp_hold%0d got rd_en=%b to=%b active=%b exp 00/0/1", i, bus.rd_en, bus.timeout_pulse, bus.pkt_active); end
      @(negedge clk);
    end
    bus.tx_ready = 1'b1;
    #1;
    n_checks++; if (bus.rd_en !== 2'b01 || bus.tx_valid !== 1'b1) begin n_errors++; $display("FAIL bp_resume got %b/%b exp 01/1", bus.rd_en, bus.tx_valid); end
    @(negedge clk);
    n_checks++; if (bus.rd_en !== 2'b01) begin n_errors++; $display("FAIL bp_eop got %b exp 01", bus.rd_en); end
    @(negedge clk);
    n_checks++; if (bus.pkt_cnt[0] !== 16'd1 || bus.state !== IDLE) begin n_errors++; $display("FAIL bp_done got cnt=%0d state=%0d exp 1/0", bus.pkt_cnt[0], bus.state); end
  endtask

  task automatic test_reset_mid_pkt();
    do_reset();
    push(1, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus.pkt_cnt[1] !== 16'd1) begin n_errors++; $display("FAIL rm_pre_cnt got %0d exp 1", bus.pkt_cnt[1]); end
    push(0, 1'b1, 1'b0); push(0, 1'b0, 1'b0); push(0, 1'b0, 1'b0); push(0, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++; if (bus.rd_en !== 2'b01 || bus.grant_id !== 1'b0) begin n_errors++; $display("FAIL rm_w1 got rd_en=%b grant=%b exp 01/0", bus.rd_en, bus.grant_id); end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_checks++; if (bus.rd_en !== 2'b00 || bus.tx_valid !== 1'b0) begin n_errors++; $display("FAIL rm_gate got rd_en=%b tx_valid=%b exp 00/0", bus.rd_en, bus.tx_valid); end
    @(negedge clk);
    n_checks++; if (bus.state !== IDLE || bus.pkt_active !== 1'b0 || bus.rd_en !== 2'b00) begin n_errors++; $display("FAIL rm_idle got state=%0d active=%b rd_en=%b exp 0/0/00", bus.state, bus.pkt_active, bus.rd_en); end
    n_checks++; if (bus.pkt_cnt !== 32'd0 || bus.drop_cnt !== 32'd0) begin n_errors++; $display("FAIL rm_cnts got %h/%h exp 0/0", bus.pkt_cnt, bus.drop_cnt); end
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus.drop_cnt[0] !== 16'd3 || bus.pkt_cnt[0] !== 16'd0 || bus.rd_en !== 2'b00) begin n_errors++; $display("FAIL rm_flush got drop=%0d pkt=%0d rd_en=%b exp 3/0/00", bus.drop_cnt[0], bus.pkt_cnt[0], bus.rd_en); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstn = 1'b0;
    bus.tx_ready = 1'b1;
    refresh();
    test_reset();
    test_single_pkt();
    test_back_to_back();
    test_orphan();
    test_timeout();
    test_backpressure();
    test_reset_mid_pkt();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
